// File: rtl/cpu_io_bridge.sv
// Host-side endpoint for the core's 32-bit I/O port: output FIFO toward the host, single-word holding register toward the core.
// Optional build macro CPU_IO_BRIDGE_CHANGE_DETECT_EN: push on CPUOut value change instead of the CPUOutWe strobe.
module cpu_io_bridge #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] IN_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic [31:0] CPUOut,
  input  logic        CPUOutWe,
  output logic [31:0] CPUIn,
  input  logic        CPUInRe,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  output logic        InFull,
  output logic        Overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} in_st_e;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, push_ok, fifo_full, fifo_empty;
  in_st_e        st_q, st_d;
  logic [31:0]   cpu_in_q, cpu_in_d;

`ifdef CPU_IO_BRIDGE_CHANGE_DETECT_EN
  logic [31:0] prev_q;
  logic        unused_we;
  assign unused_we = CPUOutWe;
  assign push      = (CPUOut != prev_q);

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) prev_q <= '0;
    else         prev_q <= CPUOut;
  end
`else
  assign push = CPUOutWe;
`endif

  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && OutReady;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset; the empty flag masks it.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= CPUOut;
  end

  assign OutValid = !fifo_empty;
  assign OutData  = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign Overflow = ovf_q;

  always_comb begin
    st_d     = st_q;
    cpu_in_d = cpu_in_q;
    case (st_q)
      S_EMPTY: if (InValid) begin
        st_d     = S_FULL;
        cpu_in_d = InData;
      end
      S_FULL:  if (CPUInRe) st_d = S_EMPTY;
      default: st_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      st_q     <= S_EMPTY;
      cpu_in_q <= IN_RESET;
    end else begin
      st_q     <= st_d;
      cpu_in_q <= cpu_in_d;
    end
  end

  assign CPUIn   = cpu_in_q;
  assign InReady = (st_q == S_EMPTY);
  assign InFull  = (st_q == S_FULL);
endmodule

// File: doc/cpu_io_bridge.md
# cpu_io_bridge

Host-side endpoint for the `risc_v` core's 32-bit I/O port: the opposite end of the core's `CPUOut`/`CPUIn` pair.
- Output path: captures each word the core writes to `CPUOut` into a small FIFO and drains it to the host over a valid/ready stream.
- Input path: accepts host words over valid/ready into a single holding register that drives the core's `CPUIn`, and tracks consumption.
- Instantiated beside `risc_v` in the top level and in system benches, replacing static `CPUIn` stimulus.

## Interface
Parameters:
- `DEPTH`, 4: output FIFO entries. Power of two, ≥2.
- `IN_RESET`, 32'h0000_0000: `CPUIn` value after reset.

Ports:
- `CLK` in 1: single clock, rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `CPUOut` in 32: core's output port value.
- `CPUOutWe` in 1: core output-write strobe, one cycle per write.
- `CPUIn` out 32: drives core's `CPUIn`.
- `CPUInRe` in 1: core has consumed `CPUIn` this cycle.
- `OutData` out 32: FIFO head word to host.
- `OutValid` out 1: FIFO non-empty.
- `OutReady` in 1: host accepts `OutData`.
- `InData` in 32: host word for core.
- `InValid` in 1: host offers `InData`.
- `InReady` out 1: holding register empty.
- `InFull` out 1: holding register holds an unconsumed word; equals `!InReady`.
- `Overflow` out 1: sticky; a core write was dropped.

## Operation
**Output path**
- Push event: `CPUOutWe`, or the change-detect condition when configured (see Configuration).
- On push with the FIFO not full, `CPUOut` is written at the write pointer.
- Pop occurs when `OutValid && OutReady`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Occupancy count is `$clog2(DEPTH)+1` bits.
- Push while full with no pop in the same cycle: the word is dropped, `Overflow` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both occur, the count stays DEPTH, and nothing is dropped.
- Push and pop in the same cycle at any other occupancy: both occur and the count is unchanged.
- `OutData` shows the head entry whenever `OutValid`=1. Its value is don't-care when empty.
- `Overflow` clears only on reset.

**Input path**
- The path has two states, EMPTY and FULL.
- EMPTY → FULL on `InValid && InReady`: `CPUIn` ← `InData`.
- FULL → EMPTY on `CPUInRe`. `CPUIn` keeps its value; the core may re-read it.
- `CPUInRe` in EMPTY is ignored.
- `InValid` in FULL is not accepted (`InReady`=0). The host must hold `InData`/`InValid` until accepted.
- `CPUInRe` and `InValid` in the same FULL cycle: the state goes to EMPTY only. The new word is accepted no earlier than the next cycle.

## Timing
Reset values while `ResetN`=0, applied asynchronously:
- `CPUIn`=`IN_RESET`, `InReady`=1, `InFull`=0.
- `OutValid`=0, `Overflow`=0, FIFO empty. `OutData`=0 (storage is not required to clear).

Latency:
- Push at edge N → `OutValid`=1 after edge N (visible in cycle N+1). There is no combinational bypass from `CPUOut` to `OutData`.
- Pop takes effect at the edge. Next head or `OutValid`=0 is visible the following cycle.
- `InData` is accepted at edge N → `CPUIn` updated and `InReady`=0 after edge N.
- `CPUInRe` at edge N → `InReady`=1 after edge N.

Other rules:
- All outputs are registered or decoded from registers only. There is no input-to-output combinational path.
- Reset asserted mid-transfer discards FIFO contents and any held word. A handshake in progress at the asserting edge is lost.
- After deassertion, operation resumes on the first rising edge.

## Configuration
Macro `CPU_IO_BRIDGE_CHANGE_DETECT_EN`:
- Defined:
  - `CPUOutWe` is ignored.
  - A push occurs on any cycle where `CPUOut` differs from a registered copy of its previous-cycle value. The registered copy resets to 0.
  - The push captures the new `CPUOut` value.
  - Intended for cores without an output strobe.
- Undefined: a push occurs only on `CPUOutWe`=1. Repeated identical values are each pushed.

## Test plan
- Reset, then idle: `CPUIn`=0, `InReady`=1, `OutValid`=0, `Overflow`=0. With `IN_RESET`=32'hF, `CPUIn`=32'h0000000F.
- Strobe mode: writes 1, 2, 3 on consecutive cycles with `OutReady`=0 → `OutValid`=1 from cycle after first write. Then raise `OutReady` → host receives 1, 2, 3 in order and `OutValid` falls after the third pop.
- Overflow, DEPTH=4: five writes (10..14), `OutReady`=0 → `Overflow`=1 and drain yields 10..13. Separately, a write while full with `OutReady`=1 → no overflow and 14 arrives last.
- Input handshake: `InData`=32'hA5, `InValid`=1 → `CPUIn`=32'hA5 and `InReady`=0. Then offer 32'h5A with `CPUInRe`=1 in the same cycle → 32'h5A is accepted one cycle later.
- Change-detect build: `CPUOut` sequence 0, 7, 7, 9, 9, 0 with `CPUOutWe`=0 → FIFO receives 7, 9, 0.
- Reset mid-operation: 3 words queued and `CPUIn` FULL, assert `ResetN`=0 asynchronously between edges → `OutValid`=0 and `InReady`=1 immediately, with no stale word output after release.
